// File: rtl/controller.sv
// Eight-phase instruction-cycle controller for a small accumulator CPU.
// The phase register is the only state besides a sticky halted flag; every strobe is decoded combinationally from it.
module controller #(
  parameter int opcode_width = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [opcode_width-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    halt,
  output logic                    ld_pc,
  output logic                    data_e,
  output logic                    ld_ac,
  output logic                    wr,
  output logic [2:0]              phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [opcode_width-1:0] OP_HLT = 3'd0;
  localparam logic [opcode_width-1:0] OP_SKZ = 3'd1;
  localparam logic [opcode_width-1:0] OP_ADD = 3'd2;
  localparam logic [opcode_width-1:0] OP_AND = 3'd3;
  localparam logic [opcode_width-1:0] OP_XOR = 3'd4;
  localparam logic [opcode_width-1:0] OP_LDA = 3'd5;
  localparam logic [opcode_width-1:0] OP_STO = 3'd6;
  localparam logic [opcode_width-1:0] OP_JMP = 3'd7;

  phase_t phase_reg;
  logic   halted_reg;
  logic   aluop;

  // A HLT seen in OP_ADDR parks the phase there instead of advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else if (!halted_reg) begin
      if (phase_reg == OP_ADDR && opcode == OP_HLT) begin
        halted_reg <= 1'b1;
      end else begin
        phase_reg <= phase_t'(3'(phase_reg + 3'd1));
      end
    end
  end

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase = phase_reg;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted_reg) begin
      halt = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = (opcode == OP_HLT);
          inc_pc = (opcode != OP_HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
          ld_ac  = aluop;
        end
        default: begin
          sel = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Bench for the controller: fixed per-phase vector table, hand-written reset/halt sequences,
// then randomized opcode/zero/reset traffic checked against a rule-based reference model.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  controller #(.opcode_width(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
    .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .phase(phase)
  );

  always #5 clk = ~clk;

  // Output bundle order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign outs = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] o;
  } vec_t;

  vec_t vec [0:63];
  int   nvec = 0;

  int mdl_ph;
  bit mdl_halt;

  task automatic add(input logic [2:0] op, input logic z, input logic [2:0] ph, input logic [8:0] o);
    vec[nvec] = '{op, z, ph, o};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d outs=%b, want phase=%0d outs=%b",
               name, act[11:9], act[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  task automatic chk_excl(input string name);
    checks++;
    if ((wr && rd) || (ld_pc && inc_pc)) begin
      errors++;
      $display("FAIL %s: exclusive strobes wr=%b rd=%b ld_pc=%b inc_pc=%b, want no overlap",
               name, wr, rd, ld_pc, inc_pc);
    end
  endtask

  // Reference rules written straight from the phase/opcode tables.
  function automatic logic [8:0] model_outs(input int ph, input bit h, input logic [2:0] op, input logic z);
    bit alu;
    logic [8:0] o;
    alu = (op >= 3'd2 && op <= 3'd5);
    if (h) return 9'b000010000;
    o[8] = (ph < 4);
    o[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    o[6] = (ph == 2 || ph == 3);
    o[5] = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z);
    o[4] = (ph == 4 && op == 3'd0);
    o[3] = (ph >= 6 && op == 3'd7);
    o[2] = (ph >= 6 && op == 3'd6);
    o[1] = (ph == 7 && alu);
    o[0] = (ph == 7 && op == 3'd6);
    return o;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_state", {phase, outs}, {3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    // ADD full loop
    add(3'd2, 0, 3'd0, 9'b100000000);
    add(3'd2, 0, 3'd1, 9'b110000000);
    add(3'd2, 0, 3'd2, 9'b111000000);
    add(3'd2, 0, 3'd3, 9'b111000000);
    add(3'd2, 0, 3'd4, 9'b000100000);
    add(3'd2, 0, 3'd5, 9'b010000000);
    add(3'd2, 0, 3'd6, 9'b010000000);
    add(3'd2, 0, 3'd7, 9'b010000010);
    // SKZ zero=1; early opcodes scrambled to show they do not matter yet
    add(3'd0, 1, 3'd0, 9'b100000000);
    add(3'd7, 1, 3'd1, 9'b110000000);
    add(3'd6, 1, 3'd2, 9'b111000000);
    add(3'd1, 1, 3'd3, 9'b111000000);
    add(3'd1, 1, 3'd4, 9'b000100000);
    add(3'd1, 1, 3'd5, 9'b000000000);
    add(3'd1, 1, 3'd6, 9'b000100000);
    add(3'd1, 1, 3'd7, 9'b000000000);
    // SKZ zero=0 with a zero blip during OP_FETCH
    add(3'd5, 0, 3'd0, 9'b100000000);
    add(3'd3, 1, 3'd1, 9'b110000000);
    add(3'd0, 0, 3'd2, 9'b111000000);
    add(3'd1, 0, 3'd3, 9'b111000000);
    add(3'd1, 0, 3'd4, 9'b000100000);
    add(3'd1, 1, 3'd5, 9'b000000000);
    add(3'd1, 0, 3'd6, 9'b000000000);
    add(3'd1, 0, 3'd7, 9'b000000000);
    // STO
    add(3'd6, 0, 3'd0, 9'b100000000);
    add(3'd6, 1, 3'd1, 9'b110000000);
    add(3'd6, 0, 3'd2, 9'b111000000);
    add(3'd6, 1, 3'd3, 9'b111000000);
    add(3'd6, 0, 3'd4, 9'b000100000);
    add(3'd6, 1, 3'd5, 9'b000000000);
    add(3'd6, 0, 3'd6, 9'b000000100);
    add(3'd6, 1, 3'd7, 9'b000000101);
    // JMP
    add(3'd7, 0, 3'd0, 9'b100000000);
    add(3'd7, 0, 3'd1, 9'b110000000);
    add(3'd7, 1, 3'd2, 9'b111000000);
    add(3'd7, 1, 3'd3, 9'b111000000);
    add(3'd7, 1, 3'd4, 9'b000100000);
    add(3'd7, 1, 3'd5, 9'b000000000);
    add(3'd7, 1, 3'd6, 9'b000001000);
    add(3'd7, 0, 3'd7, 9'b000001000);

    rst = 1'b1;
    #3;
    chk("reset_async_initial", {phase, outs}, {3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      opcode = vec[i].op;
      zero   = vec[i].z;
      #1;
      $display("vec %0d op=%0d z=%0b phase=%0d outs=%b", i, opcode, zero, phase, outs);
      chk($sformatf("vec%0d", i), {phase, outs}, {vec[i].ph, vec[i].o});
      @(posedge clk);
      #1;
    end

    // Async reset in OP_FETCH of a store, then the clean restart sequence
    do_reset();
    opcode = 3'd6;
    repeat (5) @(posedge clk);
    #1;
    chk("sto_reach_p5", {phase, outs}, {3'd5, 9'b000000000});
    #2;
    rst = 1'b1;
    #1;
    $display("async reset at phase 5: phase=%0d outs=%b", phase, outs);
    chk("async_reset_p5", {phase, outs}, {3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    chk("reset_held_edge", {phase, outs}, {3'd0, 9'b100000000});
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      $display("restart edge %0d phase=%0d", i, phase);
      chk($sformatf("restart%0d", i), {phase, outs}, {3'(i % 8), model_outs(i % 8, 0, 3'd6, zero)});
    end

    // HLT: park in OP_ADDR, ignore later opcodes, recover via reset
    opcode = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("hlt_p4", {phase, outs}, {3'd4, 9'b000010000});
    @(posedge clk);
    #1;
    chk("hlt_parked", {phase, outs}, {3'd4, 9'b000010000});
    opcode = 3'd2;
    for (int i = 0; i < 20; i++) begin
      zero = 1'($urandom);
      @(posedge clk);
      #1;
      $display("halted edge %0d op=%0d phase=%0d outs=%b", i, opcode, phase, outs);
      chk($sformatf("halted%0d", i), {phase, outs}, {3'd4, 9'b000010000});
    end
    #2;
    rst = 1'b1;
    #1;
    chk("halt_reset", {phase, outs}, {3'd0, 9'b100000000});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_resume", {phase, outs}, {3'd1, 9'b110000000});

    // Randomized traffic against the reference model
    do_reset();
    mdl_ph = 0;
    mdl_halt = 0;
    for (int i = 0; i < 300; i++) begin
      opcode = 3'($urandom);
      zero   = 1'($urandom);
      rst    = ($urandom_range(0, 19) == 0);
      if (rst) begin
        mdl_ph = 0;
        mdl_halt = 0;
      end
      #1;
      $display("rnd %0d rst=%0b op=%0d z=%0b phase=%0d outs=%b", i, rst, opcode, zero, phase, outs);
      chk($sformatf("rnd%0d", i), {phase, outs}, {3'(mdl_ph), model_outs(mdl_ph, mdl_halt, opcode, zero)});
      chk_excl($sformatf("rnd_excl%0d", i));
      @(posedge clk);
      if (!rst && !mdl_halt) begin
        if (mdl_ph == 4 && opcode == 3'd0) mdl_halt = 1;
        else mdl_ph = (mdl_ph + 1) % 8;
      end
      #1;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
